apb_initiator: RTL and testbench

APB_INITIATOR -- requirements
Module: apb_initiator

---
 rtl/apb_initiator.sv | 121 ++++++++++++
 tb/tb_apb_initiator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// Single-transfer APB initiator: accepts one host command at a time, runs the
// SETUP/ACCESS handshake with a bounded wait, and returns a one-cycle response.
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic        cmd_write_in,
    input  logic [31:0] cmd_addr_in,
    input  logic [31:0] cmd_wdata_in,
    output logic        rsp_valid_out,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_slverr_out,
    output logic        rsp_timeout_out,
    output logic        psel_out,
    output logic        penable_out,
    output logic        pwrite_out,
    output logic [31:0] paddr_out,
    output logic [31:0] pwdata_out,
    input  logic [31:0] prdata_in,
    input  logic        pready_in,
    input  logic        pslverr_in
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          done;
    logic          timeout_hit;

    assign cmd_ready_out = (state == IDLE) && !rst;
    assign accept        = cmd_valid_in && cmd_ready_out;
    assign done          = (state == ACCESS) && pready_in;
    // The limit is checked before incrementing, so pready_in arriving on the
    // cycle the counter sits at the limit still completes normally.
    assign timeout_hit   = (state == ACCESS) && !pready_in && (wait_cnt == CW'(TIMEOUT_CYCLES));

    // NOTE: state-holding logic uses non-blocking (<=) so every register samples
    // pre-edge values; combinational logic below uses blocking (=).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        psel_out    = 1'b0;
        penable_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                psel_out   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_out    = 1'b1;
                penable_out = 1'b1;
                if (done || timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrite_out      <= 1'b0;
            paddr_out       <= '0;
            pwdata_out      <= '0;
            rsp_valid_out   <= 1'b0;
            rsp_rdata_out   <= '0;
            rsp_slverr_out  <= 1'b0;
            rsp_timeout_out <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            rsp_valid_out <= 1'b0;

            if (accept) begin
                pwrite_out <= cmd_write_in;
                paddr_out  <= cmd_addr_in;
                pwdata_out <= cmd_write_in ? cmd_wdata_in : 32'd0;
            end

            if (done) begin
                rsp_valid_out   <= 1'b1;
                rsp_rdata_out   <= pwrite_out ? 32'd0 : prdata_in;
                rsp_slverr_out  <= pslverr_in;
                rsp_timeout_out <= 1'b0;
            end else if (timeout_hit) begin
                rsp_valid_out   <= 1'b1;
                rsp_rdata_out   <= 32'd0;
                rsp_slverr_out  <= 1'b1;
                rsp_timeout_out <= 1'b1;
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !pready_in && !timeout_hit) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: a scoreboard queue holds expected
// responses; per-scenario tasks check handshake timing and bus stability.
module tb_apb_initiator;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_in   (cmd_valid),
        .cmd_ready_out  (cmd_ready),
        .cmd_write_in   (cmd_write),
        .cmd_addr_in    (cmd_addr),
        .cmd_wdata_in   (cmd_wdata),
        .rsp_valid_out  (rsp_valid),
        .rsp_rdata_out  (rsp_rdata),
        .rsp_slverr_out (rsp_slverr),
        .rsp_timeout_out(rsp_timeout),
        .psel_out       (psel),
        .penable_out    (penable),
        .pwrite_out     (pwrite),
        .paddr_out      (paddr),
        .pwdata_out     (pwdata),
        .prdata_in      (prdata),
        .pready_in      (pready),
        .pslverr_in     (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Scoreboard: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got rdata=%h slverr=%b timeout=%b with nothing expected",
                         rsp_rdata, rsp_slverr, rsp_timeout);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.timeout}) begin
                    failures++;
                    $display("FAIL rsp_fields: got rdata=%h slverr=%b timeout=%b, want rdata=%h slverr=%b timeout=%b",
                             rsp_rdata, rsp_slverr, rsp_timeout, e.rdata, e.slverr, e.timeout);
                end
            end
        end
    end

    // One transfer; n_wait > TO means pready never rises and a timeout is expected.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int n_wait, input logic [31:0] rd, input logic err, input string name);
        rsp_t        e;
        int          lat;
        int          cyc;
        int          access;
        logic [31:0] exp_pwdata;
        exp_pwdata = wr ? wdata : 32'd0;
        if (n_wait > int'(TO)) begin
            lat = 3 + int'(TO);
            e   = '{rdata: 32'd0, slverr: 1'b1, timeout: 1'b1};
        end else begin
            lat = 3 + n_wait;
            e   = '{rdata: (wr ? 32'd0 : rd), slverr: err, timeout: 1'b0};
        end

        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_0000;
        exp_q.push_back(e);

        @(posedge clk); #1;
        cyc = 1; access = 0;
        // Garbage command held while busy must not disturb the bus.
        cmd_addr = ~addr; cmd_write = ~wr; cmd_wdata = ~wdata;
        checks++;
        if ({psel, penable} !== 2'b10) begin
            failures++;
            $display("FAIL %s setup: got psel/penable=%b%b want 10", name, psel, penable);
        end
        while (!rsp_valid && cyc < 40) begin
            checks++;
            if ({paddr, pwrite, pwdata} !== {addr, wr, exp_pwdata}) begin
                failures++;
                $display("FAIL %s bus_hold cyc%0d: got addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                         name, cyc, paddr, pwrite, pwdata, addr, wr, exp_pwdata);
            end
            if (psel && penable) begin
                if (access >= n_wait) begin
                    pready = 1'b1; pslverr = err; prdata = rd;
                end else begin
                    pready = 1'b0; pslverr = ~err; prdata = $urandom;
                end
                access++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid = 1'b0; pready = 1'b0; pslverr = 1'b0;
        checks++;
        if (cyc !== lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, lat);
        end
        checks++;
        if ({psel, penable} !== 2'b00 || paddr !== addr) begin
            failures++;
            $display("FAIL %s idle: got psel/penable=%b%b addr=%h want 00 addr=%h",
                     name, psel, penable, paddr, addr);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: rsp_valid still %b one cycle later, want 0", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, cmd_ready} !== '0) begin
            failures++;
            $display("FAIL reset_values: got psel=%b pen=%b wr=%b addr=%h wdata=%h rv=%b rd=%h err=%b to=%b rdy=%b want all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, cmd_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        run_xfer(1'b1, 32'h0000_008C, 32'hDEAD_BEEF, 0, 32'h1111_2222, 1'b0, "write_zero_wait");
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 3, 32'h1234_5678, 1'b0, "read_wait3");
    endtask

    task automatic test_slverr();
        run_xfer(1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1, 32'h5555_AAAA, 1'b1, "write_slverr");
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 32'h0000_0080, 32'h0, 1000, 32'h7777_7777, 1'b0, "read_timeout");
        run_xfer(1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1000, 32'h0, 1'b0, "write_timeout");
    endtask

    task automatic test_ready_at_limit();
        run_xfer(1'b0, 32'h0000_00C0, 32'h0, int'(TO), 32'hA5A5_5A5A, 1'b0, "read_ready_at_limit");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), $urandom,
                     1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100; cmd_wdata = 32'hA5A5_0001;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0BAD_F00D;
        exp_q.push_back('{rdata: 32'd0, slverr: 1'b0, timeout: 1'b0});
        @(posedge clk); #1;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 3 || psel !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got latency=%0d psel=%b want 3 and 0", cyc, psel);
        end
        cmd_write = 1'b0; cmd_addr = 32'h0000_0104;
        exp_q.push_back('{rdata: 32'h0BAD_F00D, slverr: 1'b0, timeout: 1'b0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {2'b10, 1'b0, 32'h0000_0104, 32'd0}) begin
            failures++;
            $display("FAIL b2b_second_setup: got psel=%b pen=%b wr=%b addr=%h wdata=%h want 1 0 0 00000104 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        pready = 1'b0;
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL b2b_second_latency: got %0d want 3", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int q_before;
        q_before = exp_q.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h0000_0055;
        pready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_in_access: got psel/penable=%b%b want 11", psel, penable);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, cmd_ready} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: got psel=%b pen=%b wr=%b addr=%h wdata=%h rv=%b rdy=%b want all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, cmd_ready);
        end
        pready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        pready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_release: got ready=%b psel=%b rv=%b want 1 0 0", cmd_ready, psel, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || exp_q.size() !== q_before) begin
            failures++;
            $display("FAIL rst_mid_no_rsp: got rv=%b pending=%0d want 0 and %0d", rsp_valid, exp_q.size(), q_before);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_ready_at_limit();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        run_xfer(1'b0, 32'h0000_0300, 32'h0, 0, 32'hFEED_0001, 1'b0, "read_after_reset");
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses never arrived, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
